parity_stream_gen_chk: RTL and testbench

Parametrised, handshaked parity generator/checker that processes one `DATA_W`-bit word per accepted transfer. It computes even or odd parity per word. In generate mode it emits the word with its parity bit. In check mode it compares a received parity bit against the computed one and flags mismatches. It sits between a producer and consumer on valid/ready streams, adds one register stage, and keeps a saturating error counter and a sticky error flag for status readout.

---
 rtl/parity_stream_gen_chk_pkg.sv | 19 +
 rtl/parity_stream_gen_chk_if.sv | 40 ++++
 rtl/parity_stream_gen_chk_parity_tree.sv | 14 +
 rtl/parity_stream_gen_chk.sv | 102 ++++++++++
 tb/tb_parity_stream_gen_chk.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/parity_stream_gen_chk_pkg.sv
// Shared encodings and default widths for the parity stream generator/checker.
package parity_stream_gen_chk_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 8;

    // Parity sense, carried on mode_odd.
    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_mode_e;

    // Operating mode, carried on check_en.
    typedef enum logic {
        MODE_GEN = 1'b0,
        MODE_CHK = 1'b1
    } op_mode_e;

endpackage

// File: rtl/parity_stream_gen_chk_if.sv
// Stream and status bundle for parity_stream_gen_chk.
// slave  : the parity block itself.
// master : the producer/consumer/status environment around it.
interface parity_stream_gen_chk_if
    import parity_stream_gen_chk_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_parity;
    logic              mode_odd;
    logic              check_en;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_parity;
    logic              out_err;
    logic [CNT_W-1:0]  err_cnt;
    logic              err_sticky;
    logic              clr_err;

    modport slave (
        input  in_valid, in_data, in_parity, mode_odd, check_en,
        input  out_ready, clr_err,
        output in_ready, out_valid, out_data, out_parity, out_err,
        output err_cnt, err_sticky
    );

    modport master (
        output in_valid, in_data, in_parity, mode_odd, check_en,
        output out_ready, clr_err,
        input  in_ready, out_valid, out_data, out_parity, out_err,
        input  err_cnt, err_sticky
    );

endinterface

// File: rtl/parity_stream_gen_chk_parity_tree.sv
// Combinational parity of one word: XOR reduction folded with the odd-mode bit.
module parity_tree
    import parity_stream_gen_chk_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] data,
    input  logic              odd,
    output logic              p
);

    assign p = (^data) ^ (par_mode_e'(odd) == PAR_ODD);

endmodule

// File: rtl/parity_stream_gen_chk.sv
// Parity generator/checker with one output register stage, valid/ready
// handshake on both sides, and a saturating error counter plus sticky flag.
module parity_stream_gen_chk
    import parity_stream_gen_chk_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    parity_stream_gen_chk_if.slave  bus
);

    logic              out_valid_q,  out_valid_d;
    logic [DATA_W-1:0] out_data_q,   out_data_d;
    logic              out_parity_q, out_parity_d;
    logic              out_err_q,    out_err_d;
    logic [CNT_W-1:0]  err_cnt_q,    err_cnt_d;
    logic              err_sticky_q, err_sticky_d;

    logic              par_calc;
    logic              in_ready;
    logic              accept;
    logic              release_out;
    logic              chk_mode;
    logic              err_event;

    parity_tree #(
        .DATA_W (DATA_W)
    ) u_parity_tree (
        .data (bus.in_data),
        .odd  (bus.mode_odd),
        .p    (par_calc)
    );

    // The stage can take a word when empty or when its current word leaves now.
    assign in_ready    = !out_valid_q || bus.out_ready;
    assign accept      = bus.in_valid && in_ready;
    assign release_out = out_valid_q && bus.out_ready;
    assign chk_mode    = (op_mode_e'(bus.check_en) == MODE_CHK);
    assign err_event   = accept && chk_mode && (bus.in_parity != par_calc);

    // Output stage: load on accept, drop valid on a release with no new word.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_parity_d = out_parity_q;
        out_err_d    = out_err_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_data_d   = bus.in_data;
            out_parity_d = par_calc;
            out_err_d    = chk_mode && (bus.in_parity != par_calc);
        end else if (release_out) begin
            out_valid_d  = 1'b0;
        end
    end

    // Error status: clear takes effect first so a same-cycle error still counts.
    always_comb begin
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q;
        if (bus.clr_err) begin
            err_cnt_d    = '0;
            err_sticky_d = 1'b0;
        end
        if (err_event) begin
            if (err_cnt_d != {CNT_W{1'b1}}) begin
                err_cnt_d = err_cnt_d + CNT_W'(1);
            end
            err_sticky_d = 1'b1;
        end
    end

    // State registers; reset discards any held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_parity_q <= 1'b0;
            out_err_q    <= 1'b0;
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_parity_q <= out_parity_d;
            out_err_q    <= out_err_d;
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_parity = out_parity_q;
    assign bus.out_err    = out_err_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.err_sticky = err_sticky_q;

endmodule

// File: tb/tb_parity_stream_gen_chk.sv
// Directed bench: a 4-bit generate instance and an 8-bit check/status
// instance with a 2-bit error counter, sharing clock and reset.
module tb_parity_stream_gen_chk;
    import parity_stream_gen_chk_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    parity_stream_gen_chk_if #(.DATA_W(4), .CNT_W(8)) bus4 ();
    parity_stream_gen_chk_if #(.DATA_W(8), .CNT_W(2)) bus8 ();

    parity_stream_gen_chk #(.DATA_W(4), .CNT_W(8)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    parity_stream_gen_chk #(.DATA_W(8), .CNT_W(2)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] d;
        logic       odd;
        logic       p;
    } vec_t;

    vec_t g4 [4];
    vec_t st8 [3];
    int   exp_cnt;

    initial begin
        g4[0] = '{d: 8'h06, odd: 1'b0, p: 1'b0};
        g4[1] = '{d: 8'h06, odd: 1'b1, p: 1'b1};
        g4[2] = '{d: 8'h07, odd: 1'b0, p: 1'b1};
        g4[3] = '{d: 8'h07, odd: 1'b1, p: 1'b0};
        st8[0] = '{d: 8'h11, odd: 1'b0, p: 1'b0};
        st8[1] = '{d: 8'h07, odd: 1'b0, p: 1'b1};
        st8[2] = '{d: 8'h80, odd: 1'b1, p: 1'b0};

        rst_n = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_parity = 1'b0;
        bus4.mode_odd = 1'b0; bus4.check_en = 1'b0; bus4.out_ready = 1'b1;
        bus4.clr_err = 1'b0;
        bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_parity = 1'b0;
        bus8.mode_odd = 1'b0; bus8.check_en = 1'b0; bus8.out_ready = 1'b1;
        bus8.clr_err = 1'b0;

        // Reset state
        #3;
        chk("rst_out_valid",  32'(bus8.out_valid),  0);
        chk("rst_out_data",   32'(bus8.out_data),   0);
        chk("rst_out_parity", 32'(bus8.out_parity), 0);
        chk("rst_out_err",    32'(bus8.out_err),    0);
        chk("rst_err_cnt",    32'(bus8.err_cnt),    0);
        chk("rst_err_sticky", 32'(bus8.err_sticky), 0);
        chk("rst_in_ready8",  32'(bus8.in_ready),   1);
        chk("rst_in_ready4",  32'(bus4.in_ready),   1);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(bus8.in_ready), 1);

        // Generate mode, 4-bit, consumer always ready; in_parity deliberately wrong
        for (int i = 0; i < 4; i++) begin
            bus4.in_valid  = 1'b1;
            bus4.in_data   = g4[i].d[3:0];
            bus4.mode_odd  = g4[i].odd;
            bus4.check_en  = MODE_GEN;
            bus4.in_parity = ~g4[i].p;
            if (i == 0) chk("g4_pre_valid", 32'(bus4.out_valid), 0);
            tick();
            chk($sformatf("g4_valid_%0d", i),  32'(bus4.out_valid),  1);
            chk($sformatf("g4_data_%0d", i),   32'(bus4.out_data),   32'(g4[i].d[3:0]));
            chk($sformatf("g4_parity_%0d", i), 32'(bus4.out_parity), 32'(g4[i].p));
            chk($sformatf("g4_err_%0d", i),    32'(bus4.out_err),    0);
        end
        bus4.in_valid = 1'b0;
        tick();
        chk("g4_drain_valid", 32'(bus4.out_valid), 0);
        chk("g4_err_cnt", 32'(bus4.err_cnt), 0);

        // Check mode, 8-bit, even parity on 0xA5 (computed parity 0)
        bus8.in_valid = 1'b1; bus8.in_data = 8'hA5; bus8.mode_odd = PAR_EVEN;
        bus8.check_en = MODE_CHK; bus8.in_parity = 1'b0;
        tick();
        chk("c8_good_err",    32'(bus8.out_err),    0);
        chk("c8_good_parity", 32'(bus8.out_parity), 0);
        chk("c8_good_cnt",    32'(bus8.err_cnt),    0);
        chk("c8_good_sticky", 32'(bus8.err_sticky), 0);
        bus8.in_parity = 1'b1;
        tick();
        chk("c8_bad_err",    32'(bus8.out_err),    1);
        chk("c8_bad_cnt",    32'(bus8.err_cnt),    1);
        chk("c8_bad_sticky", 32'(bus8.err_sticky), 1);
        bus8.in_valid = 1'b0;
        tick();

        // Backpressure: hold a word for three cycles while a new one waits
        bus8.in_valid = 1'b1; bus8.in_data = 8'h3C; bus8.mode_odd = PAR_EVEN;
        bus8.check_en = MODE_GEN;
        tick();
        chk("bp_first_data", 32'(bus8.out_data), 32'h3C);
        bus8.out_ready = 1'b0;
        bus8.in_data   = st8[0].d;
        bus8.mode_odd  = st8[0].odd;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_in_ready_%0d", i), 32'(bus8.in_ready), 0);
            tick();
            chk($sformatf("bp_valid_%0d", i),  32'(bus8.out_valid),  1);
            chk($sformatf("bp_data_%0d", i),   32'(bus8.out_data),   32'h3C);
            chk($sformatf("bp_parity_%0d", i), 32'(bus8.out_parity), 0);
        end
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus8.in_data  = st8[i].d;
            bus8.mode_odd = st8[i].odd;
            #1;
            chk($sformatf("st_in_ready_%0d", i), 32'(bus8.in_ready), 1);
            tick();
            chk($sformatf("st_valid_%0d", i),  32'(bus8.out_valid),  1);
            chk($sformatf("st_data_%0d", i),   32'(bus8.out_data),   32'(st8[i].d));
            chk($sformatf("st_parity_%0d", i), 32'(bus8.out_parity), 32'(st8[i].p));
        end
        bus8.in_valid = 1'b0;
        tick();
        chk("st_drain_valid", 32'(bus8.out_valid), 0);

        // Clear alone, then saturation of the 2-bit counter
        bus8.clr_err = 1'b1;
        tick();
        bus8.clr_err = 1'b0;
        chk("clr0_cnt",    32'(bus8.err_cnt),    0);
        chk("clr0_sticky", 32'(bus8.err_sticky), 0);
        bus8.in_valid = 1'b1; bus8.check_en = MODE_CHK; bus8.in_data = 8'hA5;
        bus8.mode_odd = PAR_EVEN; bus8.in_parity = 1'b0;
        tick();
        chk("chk_ok_no_count", 32'(bus8.err_cnt), 0);
        for (int i = 0; i < 5; i++) begin
            bus8.mode_odd  = (i % 2 == 0) ? PAR_EVEN : PAR_ODD;
            bus8.in_parity = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            exp_cnt = (i + 1 > 3) ? 3 : i + 1;
            chk($sformatf("sat_err_%0d", i),    32'(bus8.out_err),    1);
            chk($sformatf("sat_cnt_%0d", i),    32'(bus8.err_cnt),    32'(exp_cnt));
            chk($sformatf("sat_sticky_%0d", i), 32'(bus8.err_sticky), 1);
        end
        bus8.clr_err = 1'b1;
        tick();
        bus8.clr_err = 1'b0;
        chk("clr_err_same_cnt",    32'(bus8.err_cnt),    1);
        chk("clr_err_same_sticky", 32'(bus8.err_sticky), 1);
        bus8.in_valid = 1'b0;
        bus8.clr_err  = 1'b1;
        tick();
        bus8.clr_err = 1'b0;
        chk("clr1_cnt",    32'(bus8.err_cnt),    0);
        chk("clr1_sticky", 32'(bus8.err_sticky), 0);

        // Asynchronous reset in the middle of a stall
        bus8.in_valid = 1'b1; bus8.in_data = 8'h5A; bus8.mode_odd = PAR_EVEN;
        bus8.check_en = MODE_CHK; bus8.in_parity = 1'b1; bus8.out_ready = 1'b0;
        tick();
        bus8.in_valid = 1'b0;
        chk("ms_valid",  32'(bus8.out_valid), 1);
        chk("ms_err",    32'(bus8.out_err),   1);
        chk("ms_cnt",    32'(bus8.err_cnt),   1);
        tick();
        chk("ms_hold_data", 32'(bus8.out_data), 32'h5A);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid",  32'(bus8.out_valid),  0);
        chk("ar_out_data",   32'(bus8.out_data),   0);
        chk("ar_out_parity", 32'(bus8.out_parity), 0);
        chk("ar_out_err",    32'(bus8.out_err),    0);
        chk("ar_err_cnt",    32'(bus8.err_cnt),    0);
        chk("ar_err_sticky", 32'(bus8.err_sticky), 0);
        chk("ar_in_ready",   32'(bus8.in_ready),   1);
        #1 rst_n = 1'b1;
        bus8.in_valid = 1'b1; bus8.in_data = 8'h01; bus8.mode_odd = PAR_EVEN;
        bus8.check_en = MODE_GEN; bus8.out_ready = 1'b1;
        chk("ar_pre_valid", 32'(bus8.out_valid), 0);
        tick();
        bus8.in_valid = 1'b0;
        chk("ar_lat_valid",  32'(bus8.out_valid),  1);
        chk("ar_lat_data",   32'(bus8.out_data),   32'h01);
        chk("ar_lat_parity", 32'(bus8.out_parity), 1);
        tick();
        chk("ar_drain_valid", 32'(bus8.out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
